ss_scan_ctrl: RTL and testbench

SS_SCAN_CTRL -- requirements
Module: ss_scan_ctrl

---
 rtl/ss_scan_ctrl_if.sv | 39 +++
 rtl/ss_scan_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_ss_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ss_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// ss_scan_ctrl_if
//   Bundle of the value handshake and the multiplexed display outputs of
//   ss_scan_ctrl.
//
//   valid_i  : new value offered on data_i/mode_i
//   ready_o  : controller idle, a value can be accepted
//   data_i   : 12-bit value to display
//   mode_i   : 0 = unsigned, 1 = two's complement
//   blank_i  : suppress leading zero digits (level)
//   done_o   : one-cycle pulse when the display registers load
//   sign_o   : displayed value is negative
//   an_o     : active-low one-hot digit enable (bit 3 = thousands)
//   seg_o    : active-low segment pattern {g,f,e,d,c,b,a}
//
//   master : producer of values / consumer of the display (board or bench)
//   slave  : the scan controller itself
// ----------------------------------------------------------------------------
interface ss_scan_ctrl_if;
   logic        valid_i;
   logic        ready_o;
   logic [11:0] data_i;
   logic        mode_i;
   logic        blank_i;
   logic        done_o;
   logic        sign_o;
   logic [3:0]  an_o;
   logic [6:0]  seg_o;

   modport master (
      output valid_i, data_i, mode_i, blank_i,
      input  ready_o, done_o, sign_o, an_o, seg_o
   );

   modport slave (
      input  valid_i, data_i, mode_i, blank_i,
      output ready_o, done_o, sign_o, an_o, seg_o
   );
endinterface

// File: rtl/ss_scan_ctrl.sv
// ----------------------------------------------------------------------------
// ss_scan_ctrl
//   Accepts a 12-bit value (unsigned or two's complement), converts its
//   magnitude to four BCD digits with a serial double-dabble, and drives a
//   4-digit multiplexed seven-segment display with optional leading-zero
//   blanking and a separate sign output.
//
//   Parameters
//     SCAN_DIV : clk cycles each digit stays enabled (2..65535)
//
//   Ports
//     clk  : rising-edge clock for all state
//     rst  : asynchronous active-high reset
//     bus  : ss_scan_ctrl_if.slave (handshake, value, display outputs)
//
//   Timing: a value accepted on edge E0 is converted during the following
//   14 cycles (LOAD, 12 x CONV, UPDATE); done_o is high in the UPDATE cycle
//   and the new digits appear from the cycle after it.
// ----------------------------------------------------------------------------
module ss_scan_ctrl #(
   parameter logic [15:0] SCAN_DIV = 16'd50000
) (
   input  logic          clk,
   input  logic          rst,
   ss_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      CONV   = 2'd2,
      UPDATE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   // captured request
   logic [11:0] data_q;
   logic        mode_q;

   // conversion datapath
   logic [11:0] mag;
   logic [15:0] bcd;
   logic [15:0] bcd_adj;
   logic [3:0]  bit_cnt;
   logic        neg;

   // display registers
   logic [15:0] disp;
   logic        disp_neg;

   // scan prescaler and digit index
   logic [15:0] pre_cnt;
   logic [1:0]  idx;

   // display mux
   logic [3:0]  nib;
   logic        upper_zero;
   logic [6:0]  seg;
   logic [3:0]  an;

   logic        ready;
   logic        done;
   logic        accept;

   // Active-low segments, bit order {g,f,e,d,c,b,a}; non-decimal codes dark.
   function automatic logic [6:0] seven_segment(input logic [3:0] n);
      logic [6:0] p;
      unique case (n)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0010000;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   assign accept = bus.valid_i && ready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.valid_i) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            state_next = CONV;
         end
         CONV: begin
            if (bit_cnt == 4'd11) begin
               state_next = UPDATE;
            end
         end
         UPDATE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- double dabble
   // Add 3 to every BCD nibble >= 5 before the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned k = 0; k < 4; k++) begin
         if (bcd[k*4 +: 4] >= 4'd5) begin
            bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '0;
         mode_q   <= 1'b0;
         mag      <= '0;
         bcd      <= '0;
         bit_cnt  <= '0;
         neg      <= 1'b0;
         disp     <= '0;
         disp_neg <= 1'b0;
      end else begin
         if (accept) begin
            data_q <= bus.data_i;
            mode_q <= bus.mode_i;
         end
         unique case (state)
            LOAD: begin
               // 0 - x modulo 2^12 equals 4096 - x, so -2048 yields 2048.
               if (mode_q && data_q[11]) begin
                  mag <= 12'd0 - data_q;
               end else begin
                  mag <= data_q;
               end
               neg     <= mode_q && data_q[11];
               bcd     <= '0;
               bit_cnt <= '0;
            end
            CONV: begin
               {bcd, mag} <= {bcd_adj[14:0], mag, 1'b0};
               bit_cnt    <= bit_cnt + 4'd1;
            end
            UPDATE: begin
               disp     <= bcd;
               disp_neg <= neg;
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------- scanning
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         idx     <= '0;
      end else if (pre_cnt == SCAN_DIV - 16'd1) begin
         pre_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   // A digit above the units is blanked when it and all higher digits are 0.
   always_comb begin
      nib        = disp[3:0];
      upper_zero = 1'b0;
      unique case (idx)
         2'd0: begin
            nib        = disp[3:0];
            upper_zero = 1'b0;
         end
         2'd1: begin
            nib        = disp[7:4];
            upper_zero = (disp[15:4] == '0);
         end
         2'd2: begin
            nib        = disp[11:8];
            upper_zero = (disp[15:8] == '0);
         end
         default: begin
            nib        = disp[15:12];
            upper_zero = (disp[15:12] == '0);
         end
      endcase
      if (bus.blank_i && upper_zero) begin
         seg = '1;
      end else begin
         seg = seven_segment(nib);
      end
      an = ~(4'b0001 << idx);
   end

   assign bus.ready_o = ready;
   assign bus.done_o  = done;
   assign bus.sign_o  = disp_neg;
   assign bus.an_o    = an;
   assign bus.seg_o   = seg;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ss_scan_ctrl
//   Self-checking bench for ss_scan_ctrl with SCAN_DIV = 4. Expected display
//   contents come from decimal arithmetic on the offered value; the expected
//   digit index comes from counting clock edges since reset.
// ----------------------------------------------------------------------------
module tb_ss_scan_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ss_scan_ctrl_if bus ();

   ss_scan_ctrl #(.SCAN_DIV(16'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int         pow10  [4]  = '{1, 10, 100, 1000};

   // reference display state
   int   m_mag = 0;
   logic m_neg = 1'b0;

   // clock edges seen since reset released (drives expected digit index)
   int unsigned edges;
   always @(posedge clk) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int to_mag(input logic [11:0] d, input logic m);
      if (m && d[11]) return 4096 - int'({20'd0, d});
      return int'({20'd0, d});
   endfunction

   // compare the currently scanned digit against the reference display
   task automatic scan_sample(input string tag);
      int         i;
      logic [3:0] ea;
      logic [6:0] es;
      #1;
      i     = int'((edges / 4) % 4);
      ea    = 4'b1111;
      ea[i] = 1'b0;
      if (bus.blank_i && i > 0 && m_mag < pow10[i]) es = 7'h7F;
      else es = segtab[(m_mag / pow10[i]) % 10];
      check({tag, "/an"}, bus.an_o, ea);
      check({tag, "/seg"}, bus.seg_o, es);
      check({tag, "/sign"}, bus.sign_o, m_neg);
   endtask

   task automatic show(input string tag, input int n, input bit rand_blank);
      repeat (n) begin
         tick();
         if (rand_blank) bus.blank_i = 1'($urandom);
         scan_sample(tag);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.ready_o && n < 40) begin
         tick();
         n++;
      end
      check({tag, "/wait_ready"}, bus.ready_o, 1'b1);
   endtask

   // Called one sample after the accepting edge; follows the conversion
   // through to the display update and refreshes the reference.
   task automatic finish_conv(input string tag, input logic [11:0] d,
                              input logic m);
      int cyc   = 1;
      bit early = 0;
      check({tag, "/ready_drop"}, bus.ready_o, 1'b0);
      while (!bus.done_o && cyc < 40) begin
         tick();
         cyc++;
         if (bus.ready_o) early = 1;
      end
      check({tag, "/latency"}, cyc, 14);
      check({tag, "/busy"}, early, 0);
      scan_sample({tag, "/old"});
      tick();
      check({tag, "/done_pulse"}, bus.done_o, 1'b0);
      check({tag, "/ready_back"}, bus.ready_o, 1'b1);
      m_mag = to_mag(d, m);
      m_neg = m && d[11];
      scan_sample({tag, "/new"});
   endtask

   task automatic send(input string tag, input logic [11:0] d, input logic m);
      wait_ready(tag);
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      bus.mode_i  = m;
      tick();
      bus.valid_i = 1'b0;
      bus.data_i  = 12'($urandom);
      bus.mode_i  = 1'($urandom);
      finish_conv(tag, d, m);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [11:0] da, db;
      logic        ma, mb;
      int          cyc;
      bit          seen;

      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.mode_i  = 1'b0;
      bus.blank_i = 1'b0;

      // reset state
      #12;
      check("rst/ready", bus.ready_o, 1'b1);
      check("rst/done", bus.done_o, 1'b0);
      check("rst/sign", bus.sign_o, 1'b0);
      check("rst/an", bus.an_o, 4'b1110);
      check("rst/seg", bus.seg_o, segtab[0]);

      // transfer on the first edge after release
      @(posedge clk);
      #1;
      rst = 1'b0;
      send("u4095", 12'd4095, 1'b0);
      show("u4095", 16, 0);

      send("s_m2048", 12'h800, 1'b1);
      show("s_m2048", 16, 0);
      send("s_m1", 12'hFFF, 1'b1);
      show("s_m1", 16, 0);

      bus.blank_i = 1'b1;
      send("blank7", 12'd7, 1'b0);
      show("blank7", 16, 0);
      bus.blank_i = 1'b0;
      show("noblank7", 16, 0);

      send("u1234", 12'd1234, 1'b0);
      show("u1234", 16, 0);

      // valid held high with changing data while busy
      wait_ready("hold");
      da = 12'($urandom);
      ma = 1'($urandom);
      bus.valid_i = 1'b1;
      bus.data_i  = da;
      bus.mode_i  = ma;
      tick();
      cyc = 1;
      check("hold/ready_drop", bus.ready_o, 1'b0);
      while (!bus.done_o && cyc < 40) begin
         bus.data_i = 12'($urandom);
         bus.mode_i = 1'($urandom);
         tick();
         cyc++;
      end
      check("hold/latency", cyc, 14);
      db = 12'($urandom);
      mb = 1'($urandom);
      bus.data_i = db;
      bus.mode_i = mb;
      tick();
      check("hold/ready_rise", bus.ready_o, 1'b1);
      m_mag = to_mag(da, ma);
      m_neg = ma && da[11];
      scan_sample("hold/first");
      tick();
      bus.valid_i = 1'b0;
      finish_conv("hold/second", db, mb);
      show("hold/second", 8, 0);

      // reset in the middle of a conversion
      wait_ready("abort");
      bus.valid_i = 1'b1;
      bus.data_i  = 12'd999;
      bus.mode_i  = 1'b0;
      tick();
      bus.valid_i = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check("abort/ready", bus.ready_o, 1'b1);
      check("abort/done", bus.done_o, 1'b0);
      check("abort/an", bus.an_o, 4'b1110);
      m_mag = 0;
      m_neg = 1'b0;
      tick();
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.done_o) seen = 1;
         scan_sample("abort/digits");
      end
      check("abort/no_done", seen, 0);

      // randomized values, modes and blanking
      for (int t = 0; t < 25; t++) begin
         logic [11:0] d;
         logic        m;
         d = 12'($urandom);
         m = 1'($urandom);
         if (t % 5 == 0) d = 12'($urandom_range(0, 120));
         bus.blank_i = 1'($urandom);
         send("rand", d, m);
         show("rand", 16, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
